// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve countdown, rally, point scoring and game-over handling.
// Every output is either a state/score register or registered from the next-state decode.
module pong_game_ctrl #(
  parameter int unsigned SCORE_LIMIT  = 9,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_frame_tick,
  input  logic       i_p1_miss,
  input  logic       i_p2_miss,
  output logic [2:0] o_state,
  output logic       o_ball_en,
  output logic       o_ball_center,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic       o_game_over,
  output logic       o_winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] LIMIT       = 4'(SCORE_LIMIT);
  localparam logic [7:0] FRAMES_LAST = 8'(SERVE_FRAMES - 1);

  state_t     state, state_nxt;
  logic [7:0] frame_cnt, frame_cnt_nxt;
  logic [3:0] p1_score, p1_score_nxt;
  logic [3:0] p2_score, p2_score_nxt;
  logic       ball_en_nxt, ball_center_nxt, game_over_nxt, winner_nxt;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      frame_cnt     <= '0;
      p1_score      <= '0;
      p2_score      <= '0;
      o_ball_en     <= 1'b0;
      o_ball_center <= 1'b1;
      o_game_over   <= 1'b0;
      o_winner      <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_cnt     <= frame_cnt_nxt;
      p1_score      <= p1_score_nxt;
      p2_score      <= p2_score_nxt;
      o_ball_en     <= ball_en_nxt;
      o_ball_center <= ball_center_nxt;
      o_game_over   <= game_over_nxt;
      o_winner      <= winner_nxt;
    end
  end

  // The tick that completes the serve count moves to PLAY on that same edge.
  always_comb begin
    state_nxt     = state;
    frame_cnt_nxt = frame_cnt;
    p1_score_nxt  = p1_score;
    p2_score_nxt  = p2_score;
    case (state)
      IDLE, OVER: begin
        if (i_start) begin
          state_nxt     = SERVE;
          frame_cnt_nxt = '0;
          p1_score_nxt  = '0;
          p2_score_nxt  = '0;
        end
      end
      SERVE: begin
        if (i_frame_tick) begin
          if (frame_cnt == FRAMES_LAST) begin
            state_nxt     = PLAY;
            frame_cnt_nxt = '0;
          end else begin
            frame_cnt_nxt = frame_cnt + 8'd1;
          end
        end
      end
      PLAY: begin
        if (i_p1_miss || i_p2_miss) begin
          state_nxt = POINT;
          if (i_p1_miss && !i_p2_miss && p2_score < LIMIT)
            p2_score_nxt = p2_score + 4'd1;
          if (i_p2_miss && !i_p1_miss && p1_score < LIMIT)
            p1_score_nxt = p1_score + 4'd1;
        end
      end
      POINT: begin
        if (p1_score == LIMIT || p2_score == LIMIT) begin
          state_nxt = OVER;
        end else begin
          state_nxt     = SERVE;
          frame_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        frame_cnt_nxt = '0;
      end
    endcase
  end

  always_comb begin
    ball_en_nxt     = (state_nxt == PLAY);
    ball_center_nxt = (state_nxt != PLAY);
    game_over_nxt   = (state_nxt == OVER);
    winner_nxt      = (state_nxt == OVER) && (p2_score_nxt == LIMIT);
  end

  assign o_state    = state;
  assign o_p1_score = p1_score;
  assign o_p2_score = p2_score;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl (SCORE_LIMIT=3, SERVE_FRAMES=4): vector table,
// hand-written reset sequences, and random stimulus against a rule-level model.
module tb_pong_game_ctrl;

  localparam int LIM = 3;
  localparam int FRM = 4;

  // input packing: {rst_n, start, frame_tick, p1_miss, p2_miss}
  localparam logic [4:0] RST   = 5'b00000;
  localparam logic [4:0] NOP   = 5'b10000;
  localparam logic [4:0] START = 5'b11000;
  localparam logic [4:0] TICK  = 5'b10100;
  localparam logic [4:0] M1    = 5'b10010;
  localparam logic [4:0] M2    = 5'b10001;
  localparam logic [4:0] BOTH  = 5'b10011;

  logic       clk = 1'b0;
  logic       i_rst_n = 1'b1, i_start = 1'b0, i_frame_tick = 1'b0;
  logic       i_p1_miss = 1'b0, i_p2_miss = 1'b0;
  logic [2:0] o_state;
  logic       o_ball_en, o_ball_center, o_game_over, o_winner;
  logic [3:0] o_p1_score, o_p2_score;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(.SCORE_LIMIT(LIM), .SERVE_FRAMES(FRM)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_frame_tick(i_frame_tick),
    .i_p1_miss(i_p1_miss), .i_p2_miss(i_p2_miss), .o_state(o_state),
    .o_ball_en(o_ball_en), .o_ball_center(o_ball_center), .o_p1_score(o_p1_score),
    .o_p2_score(o_p2_score), .o_game_over(o_game_over), .o_winner(o_winner)
  );

  typedef struct {
    logic [4:0]  in;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  // expected bundle: {state, p1, p2, ball_en, ball_center, game_over, winner}
  function automatic logic [14:0] pack(input int st, input int p1, input int p2,
                                       input logic en, input logic ctr,
                                       input logic ov, input logic win);
    return {3'(st), 4'(p1), 4'(p2), en, ctr, ov, win};
  endfunction

  function automatic logic [14:0] observed();
    return {o_state, o_p1_score, o_p2_score, o_ball_en, o_ball_center, o_game_over, o_winner};
  endfunction

  task automatic add(input logic [4:0] in, input int st, input int p1, input int p2,
                     input logic en, input logic ctr, input logic ov, input logic win);
    vec_t v;
    v.in  = in;
    v.exp = pack(st, p1, p2, en, ctr, ov, win);
    vecs.push_back(v);
  endtask

  // Serve phase: three ticks stay in SERVE, the fourth enters PLAY.
  task automatic add_serve(input int p1, input int p2);
    for (int k = 0; k < FRM - 1; k++) add(TICK, 1, p1, p2, 0, 1, 0, 0);
    add(TICK, 2, p1, p2, 1, 0, 0, 0);
  endtask

  task automatic drive(input logic [4:0] in);
    {i_rst_n, i_start, i_frame_tick, i_p1_miss, i_p2_miss} = in;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [14:0] exp);
    logic [14:0] act;
    act = observed();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got st=%0d p1=%0d p2=%0d en=%b ctr=%b ov=%b win=%b, want st=%0d p1=%0d p2=%0d en=%b ctr=%b ov=%b win=%b",
               name, act[14:12], act[11:8], act[7:4], act[3], act[2], act[1], act[0],
               exp[14:12], exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Rule-level reference: game phase number plus frames seen and two scores.
  int ms, mframes, ms1, ms2;

  task automatic model_step(input logic [4:0] in);
    logic rst_n, start, tick, m1, m2;
    {rst_n, start, tick, m1, m2} = in;
    if (!rst_n) begin
      ms = 0; mframes = 0; ms1 = 0; ms2 = 0;
    end else if (ms == 0 || ms == 4) begin
      if (start) begin ms = 1; mframes = 0; ms1 = 0; ms2 = 0; end
    end else if (ms == 1) begin
      if (tick) begin
        mframes++;
        if (mframes == FRM) begin ms = 2; mframes = 0; end
      end
    end else if (ms == 2) begin
      if (m1 || m2) begin
        ms = 3;
        if (m1 && !m2) ms2 = (ms2 + 1 > LIM) ? LIM : ms2 + 1;
        if (m2 && !m1) ms1 = (ms1 + 1 > LIM) ? LIM : ms1 + 1;
      end
    end else begin
      if (ms1 == LIM || ms2 == LIM) ms = 4;
      else begin ms = 1; mframes = 0; end
    end
  endtask

  function automatic logic [14:0] model_out();
    return pack(ms, ms1, ms2, ms == 2, ms != 2, ms == 4, (ms == 4) && (ms2 == LIM));
  endfunction

  initial begin
    // ---- vector table ----
    add(RST,   0, 0, 0, 0, 1, 0, 0);
    add(TICK,  0, 0, 0, 0, 1, 0, 0);
    add(M2,    0, 0, 0, 0, 1, 0, 0);
    add(START, 1, 0, 0, 0, 1, 0, 0);
    add(START, 1, 0, 0, 0, 1, 0, 0);
    add(TICK,  1, 0, 0, 0, 1, 0, 0);
    add(TICK,  1, 0, 0, 0, 1, 0, 0);
    add(M1,    1, 0, 0, 0, 1, 0, 0);
    add(TICK,  1, 0, 0, 0, 1, 0, 0);
    add(NOP,   1, 0, 0, 0, 1, 0, 0);
    add(TICK,  2, 0, 0, 1, 0, 0, 0);
    add(START, 2, 0, 0, 1, 0, 0, 0);
    add(TICK,  2, 0, 0, 1, 0, 0, 0);
    add(M2,    3, 1, 0, 0, 1, 0, 0);
    add(NOP,   1, 1, 0, 0, 1, 0, 0);
    add_serve(1, 0);
    add(BOTH,  3, 1, 0, 0, 1, 0, 0);
    add(NOP,   1, 1, 0, 0, 1, 0, 0);
    add_serve(1, 0);
    for (int pt = 1; pt <= LIM; pt++) begin
      add(M1, 3, 1, pt, 0, 1, 0, 0);
      if (pt < LIM) begin
        add(NOP, 1, 1, pt, 0, 1, 0, 0);
        add_serve(1, pt);
      end
    end
    add(NOP,   4, 1, 3, 0, 1, 1, 1);
    add(M1,    4, 1, 3, 0, 1, 1, 1);
    add(M2,    4, 1, 3, 0, 1, 1, 1);
    add(TICK,  4, 1, 3, 0, 1, 1, 1);
    add(START, 1, 0, 0, 0, 1, 0, 0);
    add(RST,   0, 0, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].in);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // ---- reset mid-serve, then full serve count from zero ----
    drive(START);
    drive(TICK);
    drive(TICK);
    drive(RST);
    check("rst_mid_serve", pack(0, 0, 0, 0, 1, 0, 0));
    for (int k = 0; k < 3; k++) drive(TICK);
    check("tick_in_idle", pack(0, 0, 0, 0, 1, 0, 0));
    drive(START);
    for (int k = 0; k < FRM - 1; k++) drive(TICK);
    check("serve_restart_count", pack(1, 0, 0, 0, 1, 0, 0));
    drive(TICK);
    check("serve_to_play", pack(2, 0, 0, 1, 0, 0, 0));

    // ---- reset while in POINT ----
    drive(M2);
    check("enter_point", pack(3, 1, 0, 0, 1, 0, 0));
    drive(RST);
    check("rst_in_point", pack(0, 0, 0, 0, 1, 0, 0));

    // ---- randomized run against the model ----
    drive(RST);
    model_step(RST);
    for (int n = 0; n < 4000; n++) begin
      logic [4:0] in;
      in[4] = ($urandom_range(0, 199) != 0);
      in[3] = ($urandom_range(0, 19) == 0);
      in[2] = ($urandom_range(0, 2) == 0);
      in[1] = ($urandom_range(0, 7) == 0);
      in[0] = ($urandom_range(0, 7) == 0);
      model_step(in);
      drive(in);
      check($sformatf("rand%0d", n), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter SCORE_LIMIT, default 9, meaning the points that win a game; legal range 1..15.
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, meaning the frame ticks spent in SERVE before play; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port i_rst_n, input, 1, a synchronous active-low reset.
REQ-005 SHALL have port i_start, input, 1, a one-cycle start pulse (UART byte received).
REQ-006 SHALL have port i_frame_tick, input, 1, a one-cycle pulse once per video frame.
REQ-007 SHALL have port i_p1_miss, input, 1, a one-cycle pulse: ball passed player 1 paddle.
REQ-008 SHALL have port i_p2_miss, input, 1, a one-cycle pulse: ball passed player 2 paddle.
REQ-009 SHALL have port o_state, output, 3, the current state encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
REQ-010 SHALL have port o_ball_en, output, 1, which allows ball motion.
REQ-011 SHALL have port o_ball_center, output, 1, which holds the ball at screen centre.
REQ-012 SHALL have port o_p1_score, output, 4, player 1 points.
REQ-013 SHALL have port o_p2_score, output, 4, player 2 points.
REQ-014 SHALL have port o_game_over, output, 1, high while in OVER.
REQ-015 SHALL have port o_winner, output, 1, the winner: 0=P1, 1=P2; valid while o_game_over=1.

Function
REQ-016 All outputs SHALL be registered, and all state changes SHALL take effect on the clk rising edge following the qualifying input.
REQ-017 IDLE: o_ball_center=1, o_ball_en=0; i_start moves to SERVE, clears both scores and clears the frame counter.
REQ-018 SERVE: o_ball_center=1, o_ball_en=0; the 8-bit frame counter increments on each i_frame_tick.
REQ-019 SERVE: when the counter reaches SERVE_FRAMES, the block moves to PLAY and clears the counter.
REQ-020 PLAY: o_ball_en=1, o_ball_center=0.
REQ-021 PLAY: i_p1_miss alone moves to POINT and increments o_p2_score by 1.
REQ-022 PLAY: i_p2_miss alone moves to POINT and increments o_p1_score by 1.
REQ-023 PLAY: i_p1_miss and i_p2_miss in the same cycle move to POINT with no score change (replayed serve).
REQ-024 POINT lasts exactly one cycle with o_ball_en=0 and o_ball_center=1.
REQ-025 POINT: if either score equals SCORE_LIMIT, the block moves to OVER; otherwise it moves to SERVE and clears the frame counter.
REQ-026 OVER: o_game_over=1, o_ball_en=0, o_ball_center=1; o_winner=1 iff o_p2_score==SCORE_LIMIT; scores hold.
REQ-027 OVER: i_start moves to SERVE, clears the scores, clears o_game_over and clears the counter.
REQ-028 i_start SHALL be ignored in SERVE, PLAY and POINT.
REQ-029 Miss pulses SHALL be ignored outside PLAY.
REQ-030 i_frame_tick SHALL be ignored outside SERVE.
REQ-031 Scores SHALL never exceed SCORE_LIMIT and SHALL never wrap.
REQ-032 An illegal state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-033 When i_rst_n=0 at a clk edge, the block SHALL enter IDLE with o_state=0, scores=0, o_ball_en=0, o_ball_center=1, o_game_over=0, o_winner=0, and frame counter=0.
REQ-034 Reset SHALL take priority over every other input in any state, including mid-SERVE count and POINT.
REQ-035 No output SHALL change asynchronously to clk.

Verification (SCORE_LIMIT=3, SERVE_FRAMES=4)
REQ-036 Reset then i_start pulse -> o_state=1 next cycle; after 4 i_frame_tick pulses -> o_state=2, o_ball_en=1.
REQ-037 In PLAY pulse i_p2_miss -> o_state=3 for one cycle, o_p1_score=1, then o_state=1 with the counter restarting at 0.
REQ-038 In PLAY pulse i_p1_miss and i_p2_miss together -> scores unchanged, POINT then SERVE.
REQ-039 Drive P2 to 3 points via i_p1_miss -> o_state=4, o_game_over=1, o_winner=1; further miss pulses leave o_p2_score=3.
REQ-040 In OVER pulse i_start -> o_state=1, scores=0, o_game_over=0; i_start during SERVE/PLAY -> no effect.
REQ-041 Assert i_rst_n=0 for one cycle after 2 frame ticks in SERVE -> IDLE with all reset values; frame ticks in IDLE -> no state change.
